// File: rtl/router_reg_param.sv
// Router input-path register stage: latches the header, buffers one word while the
// channel FIFO is full, and checks packet checksum and payload length.
module router_reg_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int PAR_MODE = 0,
    parameter int LEN_CHK  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              fifo_full,
    input  logic              detect_addr,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err
);
    localparam int CNT_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_int_par;
    logic [DATA_W-1:0] r_ext_par;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dout_vld;
    logic              r_parity_done;
    logic              r_parity_done_d;
    logic              r_low_pkt_valid;
    logic              r_err;
    logic              r_len_err;

    logic              w_addr_ok;
    logic              w_hdr_load;
    logic              w_acc_hdr;
    logic              w_acc_din;
    logic              w_par_cap;
    logic              w_chk;
    logic [DATA_W-1:0] w_acc_in;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]  w_len;

    // The all-ones destination is reserved, so such a header never replaces r_hdr.
    assign w_addr_ok  = (din[ADDR_W-1:0] != {ADDR_W{1'b1}});
    assign w_hdr_load = detect_addr & pkt_valid & w_addr_ok;
    assign w_acc_hdr  = lfd_state & pkt_valid;
    assign w_acc_din  = ld_state & pkt_valid & ~full_state;
    assign w_acc_in   = w_acc_hdr ? r_hdr : din;
    assign w_acc_nxt  = (PAR_MODE == 1) ? (r_int_par + w_acc_in) : (r_int_par ^ w_acc_in);
    assign w_par_cap  = (ld_state & ~fifo_full & ~pkt_valid)
                      | (laf_state & r_low_pkt_valid & ~r_parity_done);
    assign w_chk      = r_parity_done & ~r_parity_done_d;
    assign w_len      = r_hdr[DATA_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hdr      <= '0;
            r_hold     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            if (w_hdr_load)
                r_hdr <= din;
            r_dout_vld <= 1'b0;
            if (lfd_state) begin
                r_dout     <= r_hdr;
                r_dout_vld <= 1'b1;
            end else if (ld_state && !fifo_full) begin
                r_dout     <= din;
                r_dout_vld <= 1'b1;
            end else if (ld_state) begin
                r_hold <= din;
            end else if (laf_state) begin
                r_dout     <= r_hold;
                r_dout_vld <= 1'b1;
            end
        end
    end

    // A new header always restarts the packet bookkeeping, even on a parity event.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_int_par       <= '0;
            r_ext_par       <= '0;
            r_cnt           <= '0;
            r_parity_done   <= 1'b0;
            r_parity_done_d <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
        end else if (detect_addr) begin
            r_int_par       <= '0;
            r_ext_par       <= '0;
            r_cnt           <= '0;
            r_parity_done   <= 1'b0;
            r_parity_done_d <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
        end else begin
            if (w_acc_hdr || w_acc_din)
                r_int_par <= w_acc_nxt;
            if (w_acc_din && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
            if (w_par_cap) begin
                r_ext_par     <= din;
                r_parity_done <= 1'b1;
            end
            r_parity_done_d <= r_parity_done;
            if (w_chk) begin
                r_err     <= (r_int_par != r_ext_par);
                r_len_err <= (LEN_CHK != 0) && (r_cnt != w_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_low_pkt_valid <= 1'b0;
        else if (rst_int_reg)
            r_low_pkt_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            r_low_pkt_valid <= 1'b1;
    end

    assign dout          = r_dout;
    assign dout_vld      = r_dout_vld;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign len_err       = r_len_err;
endmodule
